fetch_sequencer: RTL and testbench

Sequences instruction fetch between the PC and a variable-latency instruction memory. It issues word requests with a req/ready handshake and advances the PC. Jump redirects squash any in-flight request, and a one-entry skid buffer absorbs a response that arrives while the decode stage is stalled. It sits between the IF/ID register and the instruction memory and replaces a free-running PC incrementer.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid.sv | 34 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional feature macro used by fetch_sequencer: FETCH_SEQ_PERF_EN.
package fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction/pc buffer that absorbs a response arriving while decode is stalled.
// Clear wins over load, load wins over unload.
module fetch_skid #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC, req/ready handshake to instruction memory, jump squash and skid buffer.
// Define FETCH_SEQ_PERF_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
`ifdef FETCH_SEQ_PERF_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_bubble_cnt,
`endif
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc_nx, pc_inc, target, drain_addr;
    logic              consume, drain_ld;
    logic              slot_clr, slot_ld_fresh, slot_ld_skid;
    logic              skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    assign target    = {jump_target[ADDR_W-1:2], 2'b00};
    assign pc_inc    = pc + ADDR_W'(WORD_BYTES);
    assign consume   = if_valid & ~stall;
    assign imem_req  = (state == REQ) || (state == DRAIN);
    // pc already holds the redirect target in DRAIN; the abandoned request keeps its own address
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        drain_ld      = 1'b0;
        slot_clr      = 1'b0;
        slot_ld_fresh = 1'b0;
        slot_ld_skid  = 1'b0;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        skid_clear    = 1'b0;
        case (state)
            IDLE: begin
                state_nx = REQ;
                if (jump) begin
                    pc_nx    = target;
                    slot_clr = 1'b1;
                end
            end
            REQ: begin
                if (jump) begin
                    pc_nx      = target;
                    slot_clr   = 1'b1;
                    skid_clear = 1'b1;
                    drain_ld   = !imem_ready;
                    state_nx   = imem_ready ? REQ : DRAIN;
                end else if (imem_ready) begin
                    pc_nx = pc_inc;
                    if (!if_valid || consume) begin
                        slot_ld_fresh = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_nx  = HOLD;
                    end
                end else if (consume) begin
                    slot_clr = 1'b1;
                end
            end
            HOLD: begin
                if (jump) begin
                    pc_nx      = target;
                    slot_clr   = 1'b1;
                    skid_clear = 1'b1;
                    state_nx   = REQ;
                end else if (consume) begin
                    slot_ld_skid = 1'b1;
                    skid_unload  = 1'b1;
                    state_nx     = REQ;
                end
            end
            DRAIN: begin
                if (jump) begin
                    pc_nx    = target;
                    slot_clr = 1'b1;
                end
                if (imem_ready) state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (drain_ld) drain_addr <= pc;
            if (slot_clr) begin
                if_valid <= 1'b0;
            end else if (slot_ld_fresh) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end else if (slot_ld_skid) begin
                if_valid <= skid_full;
                if_instr <= skid_instr;
                if_pc    <= skid_pc;
            end
        end
    end

    fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

`ifdef FETCH_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (consume) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state != IDLE && !stall && !if_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios push expected if_pc values,
// a monitor pops and compares on every consumed instruction.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          budget = 0;
    int          wait_cycles = 0;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .jump        (jump),
        .jump_target (jump_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
`ifdef FETCH_SEQ_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers after wait_cycles idle request cycles, until budget is spent.
    initial begin
        int          wcnt = 0;
        logic        last_pending = 1'b0;
        logic [31:0] last_addr = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ready = 1'b0;
            if (reset && last_pending && imem_req) begin
                checks++;
                if (imem_addr !== last_addr) begin
                    errors++;
                    $display("FAIL addr_stable: got %h expected %h", imem_addr, last_addr);
                end
            end
            if (reset && imem_req && budget > 0) begin
                if (wcnt >= wait_cycles) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    budget--;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            last_pending = reset && imem_req && !imem_ready;
            last_addr    = imem_addr;
        end
    end

    // Monitor: every consumed slot must match the next expected address and its word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && if_valid && !stall) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_delivery: got pc %h expected none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc !== e || if_instr !== mem_word(e)) begin
                        errors++;
                        $display("FAIL delivery: got pc %h instr %h expected pc %h instr %h",
                                 if_pc, if_instr, e, mem_word(e));
                    end
                end
            end
        end
    end

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        jump = 1'b0;
        stall = 1'b0;
        jump_target = '0;
        @(negedge clk);
        budget = 0;
        exp_q.delete();
        @(negedge clk);
        chk({tag, "_rst_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_rst_imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_rst_if_instr"}, if_instr, 32'd0);
        chk({tag, "_rst_if_pc"}, if_pc, 32'd0);
        chk({tag, "_rst_pc"}, pc, 32'h100);
        chk({tag, "_rst_imem_addr"}, imem_addr, 32'h100);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        jump = 1'b0;
        stall = 1'b0;
        jump_target = '0;

        // Zero-wait streaming from RESET_PC
        do_reset("t1");
        wait_cycles = 0;
        budget = 3;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        release_reset();
        @(negedge clk);
        chk("t1_first_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h100);
        @(negedge clk);
        chk("t1_addr1", imem_addr, 32'h104);
        chk("t1_valid1", 32'(if_valid), 32'd1);
        chk("t1_ifpc1", if_pc, 32'h100);
        @(negedge clk);
        chk("t1_addr2", imem_addr, 32'h108);
        chk("t1_ifpc2", if_pc, 32'h104);
        repeat (4) @(negedge clk);
        drained("t1");

        // Three wait cycles per access
        do_reset("t2");
        wait_cycles = 3;
        budget = 2;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        release_reset();
        repeat (4) @(negedge clk);
        chk("t2_ready_first", 32'(imem_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_addr_held", imem_addr, 32'h104);
            chk("t2_valid_pulse", 32'(if_valid), (i == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("t2_valid_second", 32'(if_valid), 32'd1);
        chk("t2_ifpc_second", if_pc, 32'h104);
        repeat (3) @(negedge clk);
        drained("t2");

        // Stall for five cycles while a response lands in the skid buffer
        do_reset("t3");
        wait_cycles = 0;
        budget = 3;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        release_reset();
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_req", 32'(imem_req), 32'd0);
            chk("t3_hold_ifpc", if_pc, 32'h100);
        end
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        chk("t3_resume_addr", imem_addr, 32'h108);
        chk("t3_skid_ifpc", if_pc, 32'h104);
        repeat (4) @(negedge clk);
        drained("t3");

        // Jump while a request is pending: drain, discard, refetch at aligned target
        do_reset("t4");
        wait_cycles = 2;
        budget = 4;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h2000);
        release_reset();
        repeat (7) @(negedge clk);
        chk("t4_pre_addr", imem_addr, 32'h108);
        jump = 1'b1;
        jump_target = 32'h2002;
        @(negedge clk);
        jump = 1'b0;
        chk("t4_drain_req", 32'(imem_req), 32'd1);
        chk("t4_drain_addr", imem_addr, 32'h108);
        chk("t4_drain_pc", pc, 32'h2000);
        chk("t4_drain_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("t4_drain_valid2", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("t4_redirect_addr", imem_addr, 32'h2000);
        chk("t4_redirect_valid", 32'(if_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("t4_valid_before", 32'(if_valid), 32'd0);
        @(negedge clk);
        chk("t4_valid_after", 32'(if_valid), 32'd1);
        repeat (3) @(negedge clk);
        drained("t4");

        // Jump in the same cycle as a response
        do_reset("t5");
        wait_cycles = 0;
        budget = 3;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h3000);
        release_reset();
        @(negedge clk);
        @(negedge clk);
        chk("t5_ready_with_jump", 32'(imem_ready), 32'd1);
        jump = 1'b1;
        jump_target = 32'h3000;
        @(negedge clk);
        jump = 1'b0;
        chk("t5_addr_target", imem_addr, 32'h3000);
        chk("t5_no_stale", 32'(if_valid), 32'd0);
        repeat (4) @(negedge clk);
        drained("t5");

        // PC wrap at the top of the address space
        do_reset("t6");
        wait_cycles = 0;
        budget = 3;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        release_reset();
        @(negedge clk);
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        @(negedge clk);
        jump = 1'b0;
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t6_addr_wrap", imem_addr, 32'h0);
        repeat (4) @(negedge clk);
        drained("t6");

        // Reset asserted in the middle of DRAIN
        do_reset("t7");
        wait_cycles = 3;
        budget = 2;
        release_reset();
        @(negedge clk);
        jump = 1'b1;
        jump_target = 32'h4000;
        @(negedge clk);
        jump = 1'b0;
        chk("t7_drain_addr", imem_addr, 32'h100);
        chk("t7_drain_pc", pc, 32'h4000);
        #1;
        reset = 1'b0;
        #1;
        chk("t7_rst_req", 32'(imem_req), 32'd0);
        chk("t7_rst_pc", pc, 32'h100);
        chk("t7_rst_valid", 32'(if_valid), 32'd0);
        repeat (3) @(negedge clk);
        drained("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
